// File: rtl/butterfly.sv
// Radix-2 DIT FFT butterfly with a constant complex twiddle W.
// out1 = A + W*B, out2 = A - W*B; two registered stages, wrap-around arithmetic.
module butterfly #(
  parameter int WIDTH   = 16,
  parameter int w_r     = 2,
  parameter int w_i     = 3,
  parameter int TW_FRAC = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in1_r,
  input  logic signed [WIDTH-1:0] in1_i,
  input  logic signed [WIDTH-1:0] in2_r,
  input  logic signed [WIDTH-1:0] in2_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out1_r,
  output logic signed [WIDTH-1:0] out1_i,
  output logic signed [WIDTH-1:0] out2_r,
  output logic signed [WIDTH-1:0] out2_i
);

  localparam int PW = 2 * WIDTH + 1;

  // Twiddle components are WIDTH-bit signed values, sign-extended to product width.
  localparam logic signed [WIDTH-1:0] WR_W   = WIDTH'(w_r);
  localparam logic signed [WIDTH-1:0] WI_W   = WIDTH'(w_i);
  localparam logic signed [PW-1:0]    WR_EXT = PW'(WR_W);
  localparam logic signed [PW-1:0]    WI_EXT = PW'(WI_W);

  // Index 0 holds the real component, index 1 the imaginary component.
  logic [1:0][WIDTH-1:0] a_reg;
  logic [1:0][WIDTH-1:0] p_reg;
  logic [1:0][WIDTH-1:0] p_next;
  logic [1:0][WIDTH-1:0] sum_next;
  logic [1:0][WIDTH-1:0] diff_next;
  logic [1:0][WIDTH-1:0] out1_reg;
  logic [1:0][WIDTH-1:0] out2_reg;
  logic                  valid1_reg;
  logic                  valid2_reg;

  logic signed [PW-1:0]  b_r_ext;
  logic signed [PW-1:0]  b_i_ext;
  logic signed [PW-1:0]  prod_r;
  logic signed [PW-1:0]  prod_i;

  // Full-precision complex multiply, floor shift, keep the low WIDTH bits.
  always_comb begin
    b_r_ext   = PW'(in2_r);
    b_i_ext   = PW'(in2_i);
    prod_r    = WR_EXT * b_r_ext - WI_EXT * b_i_ext;
    prod_i    = WR_EXT * b_i_ext + WI_EXT * b_r_ext;
    p_next    = '0;
    p_next[0] = WIDTH'(prod_r >>> TW_FRAC);
    p_next[1] = WIDTH'(prod_i >>> TW_FRAC);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      assign sum_next[gi]  = a_reg[gi] + p_reg[gi];
      assign diff_next[gi] = a_reg[gi] - p_reg[gi];
    end
  endgenerate

  // Data stages load only on a qualified sample, so idle cycles hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      p_reg      <= '0;
      out1_reg   <= '0;
      out2_reg   <= '0;
      valid1_reg <= 1'b0;
      valid2_reg <= 1'b0;
    end else begin
      valid1_reg <= in_valid;
      valid2_reg <= valid1_reg;
      if (in_valid) begin
        a_reg <= {in1_i, in1_r};
        p_reg <= p_next;
      end
      if (valid1_reg) begin
        out1_reg <= sum_next;
        out2_reg <= diff_next;
      end
    end
  end

  assign out_valid = valid2_reg;
  assign out1_r    = out1_reg[0];
  assign out1_i    = out1_reg[1];
  assign out2_r    = out2_reg[0];
  assign out2_i    = out2_reg[1];

endmodule

// File: tb/tb_butterfly.sv
// Scoreboard bench for butterfly: a default-twiddle instance and a W=-j Q14 instance
// share one stimulus stream; expected results are queued at drive time and popped on out_valid.
module tb_butterfly;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic signed [15:0] in1_r, in1_i, in2_r, in2_i;
  logic        ov   [2];
  logic [15:0] o1r  [2];
  logic [15:0] o1i  [2];
  logic [15:0] o2r  [2];
  logic [15:0] o2i  [2];

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] last_exp [2];

  butterfly #(.WIDTH(16), .w_r(2), .w_i(3), .TW_FRAC(0)) dut_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .out_valid(ov[0]), .out1_r(o1r[0]), .out1_i(o1i[0]),
    .out2_r(o2r[0]), .out2_i(o2i[0])
  );

  butterfly #(.WIDTH(16), .w_r(0), .w_i(-16384), .TW_FRAC(14)) dut_q14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_r(in1_r), .in1_i(in1_i), .in2_r(in2_r), .in2_i(in2_i),
    .out_valid(ov[1]), .out1_r(o1r[1]), .out1_i(o1i[1]),
    .out2_r(o2r[1]), .out2_i(o2i[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {out1_r, out1_i, out2_r, out2_i}
  function automatic logic [63:0] model(input logic signed [15:0] ar, ai, br, bi,
                                        input int wr, wi, frac);
    longint pr, pi;
    logic [15:0] pr16, pi16, s_r, s_i, d_r, d_i;
    pr   = (longint'(wr) * longint'(br) - longint'(wi) * longint'(bi)) >>> frac;
    pi   = (longint'(wr) * longint'(bi) + longint'(wi) * longint'(br)) >>> frac;
    pr16 = pr[15:0];
    pi16 = pi[15:0];
    s_r  = ar + pr16;
    s_i  = ai + pi16;
    d_r  = ar - pr16;
    d_i  = ai - pi16;
    return {s_r, s_i, d_r, d_i};
  endfunction

  task automatic send(input logic v, input logic signed [15:0] ar, ai, br, bi);
    @(negedge clk);
    in_valid = v;
    in1_r = ar; in1_i = ai; in2_r = br; in2_i = bi;
    if (v) begin
      q0.push_back(model(ar, ai, br, bi, 2, 3, 0));
      q1.push_back(model(ar, ai, br, bi, 0, -16384, 14));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic watch(input int d, input logic v, input logic [63:0] got);
    logic [63:0] exp;
    if (!rst_n) begin
      chk($sformatf("reset%0d", d), {v, got}, 65'd0);
      last_exp[d] = '0;
    end else if (v) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk($sformatf("unexp_valid%0d", d), 65'd1, 65'd0);
      end else begin
        exp = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("out%0d", d), {1'b1, got}, {1'b1, exp});
        last_exp[d] = exp;
        $display("dut%0d out1=(%0d,%0d) out2=(%0d,%0d)", d,
                 $signed(got[63:48]), $signed(got[47:32]),
                 $signed(got[31:16]), $signed(got[15:0]));
      end
    end else begin
      chk($sformatf("hold%0d", d), {1'b0, got}, {1'b0, last_exp[d]});
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) watch(d, ov[d], {o1r[d], o1i[d], o2r[d], o2i[d]});
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in1_r = '0; in1_i = '0; in2_r = '0; in2_i = '0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // Single sample, then let out_valid fall
    send(1'b1, 16'sd10, 16'sd5, 16'sd3, 16'sd2);
    idle(4);

    // Back-to-back stream
    send(1'b1, 16'sd10, 16'sd5, 16'sd3, 16'sd2);
    send(1'b1, 16'sd0, 16'sd0, 16'sd1, 16'sd0);
    send(1'b1, -16'sd1, 16'sd0, 16'sd0, 16'sd1);
    idle(4);

    // W=-j case and a wrap-around case
    send(1'b1, 16'sd100, 16'sd50, 16'sd20, -16'sd40);
    send(1'b1, 16'sd32767, 16'sd0, 16'sd1, 16'sd0);
    idle(3);

    // Randomised traffic with gaps; idle beats carry junk data that must be ignored
    for (int i = 0; i < 24; i++) begin
      send(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
    end
    idle(4);

    // Asynchronous reset with a sample in flight
    send(1'b1, 16'sd1234, -16'sd77, 16'sd55, 16'sd66);
    void'(q0.pop_back());
    void'(q1.pop_back());
    @(posedge clk);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("async_rst%0d", d), {ov[d], o1r[d], o1i[d], o2r[d], o2i[d]}, 65'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 10 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    chk("drain", 65'(q0.size() + q1.size()), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
